// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 Hz raster timing constants shared by the timing generator.
package vga_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Coordinate width is sized from the larger of the two totals (10 bits here).
  localparam int COORD_W = $clog2((H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL);

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping counter with sync-window and active-window decode.
// The registered sync flag is computed from the next count so it always describes
// the count presented in the same cycle.
module vga_axis_counter #(
  parameter int W          = 10,
  parameter int TOTAL      = 800,
  parameter int ACTIVE     = 640,
  parameter int SYNC_START = 656,
  parameter int SYNC_LEN   = 96
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         adv,
  output logic [W-1:0] count,
  output logic         at_last,
  output logic         wrap,
  output logic         in_sync,
  output logic         active_next
);

  localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_END = W'(ACTIVE);
  localparam logic [W-1:0] SYN_LO  = W'(SYNC_START);
  localparam logic [W-1:0] SYN_HI  = W'(SYNC_START + SYNC_LEN - 1);

  logic [W-1:0] count_next;
  logic         sync_next;

  assign at_last = (count == LAST);
  // Out-of-range counts are treated like the last count so they recover on the next advance.
  assign wrap    = adv && (count >= LAST);

  // Next-count and window decode.
  always_comb begin
    count_next = count;
    if (adv) begin
      count_next = (count >= LAST) ? '0 : count + 1'b1;
    end
    sync_next   = (count_next >= SYN_LO) && (count_next <= SYN_HI);
    active_next = (count_next < ACT_END);
  end

  // Counter and sync flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      in_sync <= 1'b0;
    end else begin
      count   <= count_next;
      in_sync <= sync_next;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: H counter advances on CE, V counter on H wrap.
// Sync and blank are registered from next-state counts for zero skew against x/y.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE_P = H_ACTIVE,
  parameter int H_FP_P     = H_FP,
  parameter int H_SYNC_P   = H_SYNC,
  parameter int H_BP_P     = H_BP,
  parameter int V_ACTIVE_P = V_ACTIVE,
  parameter int V_FP_P     = V_FP,
  parameter int V_SYNC_P   = V_SYNC,
  parameter int V_BP_P     = V_BP,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               CE,
  output logic               HS,
  output logic               VS,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               blank,
  output logic               line_end,
  output logic               frame_end
);

  localparam int H_TOT = H_ACTIVE_P + H_FP_P + H_SYNC_P + H_BP_P;
  localparam int V_TOT = V_ACTIVE_P + V_FP_P + V_SYNC_P + V_BP_P;

  logic h_at_last, h_wrap, h_sync, h_active_next;
  logic v_at_last, v_wrap, v_sync, v_active_next;
  logic blank_reg;

  vga_axis_counter #(
    .W(COORD_W), .TOTAL(H_TOT), .ACTIVE(H_ACTIVE_P),
    .SYNC_START(H_ACTIVE_P + H_FP_P), .SYNC_LEN(H_SYNC_P)
  ) u_h (
    .clk(CLK), .rst_n(RST_N), .adv(CE),
    .count(x), .at_last(h_at_last), .wrap(h_wrap),
    .in_sync(h_sync), .active_next(h_active_next)
  );

  // V advances only on the H wrap, so VS changes together with x returning to 0.
  vga_axis_counter #(
    .W(COORD_W), .TOTAL(V_TOT), .ACTIVE(V_ACTIVE_P),
    .SYNC_START(V_ACTIVE_P + V_FP_P), .SYNC_LEN(V_SYNC_P)
  ) u_v (
    .clk(CLK), .rst_n(RST_N), .adv(h_wrap),
    .count(y), .at_last(v_at_last), .wrap(v_wrap),
    .in_sync(v_sync), .active_next(v_active_next)
  );

  // Blank register, computed from the next-state active flags of both axes.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      blank_reg <= 1'b0;
    end else begin
      blank_reg <= !(h_active_next && v_active_next);
    end
  end

  assign blank     = blank_reg;
  assign HS        = h_sync ? HS_POL : ~HS_POL;
  assign VS        = v_sync ? VS_POL : ~VS_POL;
  assign line_end  = h_wrap && h_at_last;
  assign frame_end = line_end && v_wrap && v_at_last;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default-timing instance for line, CE and
// reset behaviour, and a reduced-timing instance (inverted polarities) for full frames.
module tb_vga_timing_gen;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0, CE = 1'b1;
  logic       HS, VS, blank, line_end, frame_end;
  logic [9:0] x, y;

  logic       RST_N_s = 1'b0, CE_s = 1'b1;
  logic       HS_s, VS_s, blank_s, line_end_s, frame_end_s;
  logic [9:0] x_s, y_s;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  vga_timing_gen dut (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .HS(HS), .VS(VS), .x(x), .y(y),
    .blank(blank), .line_end(line_end), .frame_end(frame_end)
  );

  // Small raster: H 8+2+3+2=15 (HS x=10..12), V 6+1+2+2=11 (VS y=7..8), active-high syncs.
  vga_timing_gen #(
    .H_ACTIVE_P(8), .H_FP_P(2), .H_SYNC_P(3), .H_BP_P(2),
    .V_ACTIVE_P(6), .V_FP_P(1), .V_SYNC_P(2), .V_BP_P(2),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_s (
    .CLK(CLK), .RST_N(RST_N_s), .CE(CE_s), .HS(HS_s), .VS(VS_s), .x(x_s), .y(y_s),
    .blank(blank_s), .line_end(line_end_s), .frame_end(frame_end_s)
  );

  // Per-cycle consistency of blank/HS/VS against the presented coordinates.
  always @(negedge CLK) begin
    total++;
    if (blank !== ((x >= 640) || (y >= 480)) ||
        HS !== !((x >= 656) && (x <= 751)) ||
        VS !== !((y >= 490) && (y <= 491))) begin
      bad++;
      $display("FAIL checker: x=%0d y=%0d blank=%b HS=%b VS=%b", x, y, blank, HS, VS);
    end
  end

  task automatic test_reset();
    RST_N = 1'b0;
    CE = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      total++;
      if ({x, y, HS, VS, blank, line_end, frame_end} !== {10'd0, 10'd0, 5'b11000}) begin
        bad++;
        $display("FAIL reset: x=%0d y=%0d HS=%b VS=%b blank=%b le=%b fe=%b required 0 0 1 1 0 0 0",
                 x, y, HS, VS, blank, line_end, frame_end);
      end
    end
    $display("reset: 5 cycles held");
  endtask

  task automatic test_line();
    int hs_low = 0, blanks = 0, les = 0;
    RST_N = 1'b1;
    for (int i = 0; i < 800; i++) begin
      total++;
      if (x !== 10'(i) || y !== 10'd0 || HS !== !((i >= 656) && (i <= 751)) ||
          blank !== (i >= 640) || line_end !== (i == 799) || frame_end !== 1'b0) begin
        bad++;
        $display("FAIL line: x=%0d y=%0d HS=%b blank=%b le=%b fe=%b required x=%0d y=0",
                 x, y, HS, blank, line_end, frame_end, i);
      end
      if (!HS) hs_low++;
      if (blank) blanks++;
      if (line_end) les++;
      @(negedge CLK);
    end
    total++;
    if (hs_low != 96 || blanks != 160 || les != 1 || x !== 10'd0 || y !== 10'd1) begin
      bad++;
      $display("FAIL line_summary: hs_low=%0d blank=%0d line_end=%0d x=%0d y=%0d required 96 160 1 0 1",
               hs_low, blanks, les, x, y);
    end
    $display("line: hs_low=%0d blank=%0d line_end=%0d", hs_low, blanks, les);
  endtask

  task automatic run_to_x(input int target);
    int n = 0;
    while (x !== 10'(target) && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    total++;
    if (x !== 10'(target)) begin
      bad++;
      $display("FAIL run_to_x: x=%0d required %0d", x, target);
    end
  endtask

  task automatic test_ce_gating();
    logic [3:0] ce_seq = 4'b1001;   // applied MSB first: 1,0,0,1
    int         x_exp[4] = '{11, 11, 11, 12};
    run_to_x(10);
    for (int i = 0; i < 4; i++) begin
      CE = ce_seq[3-i];
      @(negedge CLK);
      total++;
      if (x !== 10'(x_exp[i]) || y !== 10'd1 || line_end !== 1'b0 || frame_end !== 1'b0) begin
        bad++;
        $display("FAIL ce_gating step %0d: x=%0d y=%0d le=%b required x=%0d y=1 le=0",
                 i, x, y, line_end, x_exp[i]);
      end
    end
    CE = 1'b1;
    $display("ce_gating: final x=%0d", x);
  endtask

  task automatic test_async_reset();
    run_to_x(700);
    @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    total++;
    if ({x, y, HS, VS, blank} !== {10'd0, 10'd0, 3'b110}) begin
      bad++;
      $display("FAIL async_reset: x=%0d y=%0d HS=%b VS=%b blank=%b required 0 0 1 1 0",
               x, y, HS, VS, blank);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    total++;
    if (x !== 10'd1 || y !== 10'd0) begin
      bad++;
      $display("FAIL async_release: x=%0d y=%0d required 1 0", x, y);
    end
    $display("async_reset: after release x=%0d y=%0d", x, y);
  endtask

  task automatic test_frame();
    int mx = 0, my = 0, fes = 0, vs_on = 0;
    RST_N_s = 1'b1;
    for (int i = 0; i < 2 * 165; i++) begin
      total++;
      if (x_s !== 10'(mx) || y_s !== 10'(my) ||
          HS_s !== ((mx >= 10) && (mx <= 12)) || VS_s !== ((my >= 7) && (my <= 8)) ||
          blank_s !== ((mx >= 8) || (my >= 6)) || line_end_s !== (mx == 14) ||
          frame_end_s !== ((mx == 14) && (my == 10))) begin
        bad++;
        $display("FAIL frame: x=%0d y=%0d HS=%b VS=%b blank=%b le=%b fe=%b required x=%0d y=%0d",
                 x_s, y_s, HS_s, VS_s, blank_s, line_end_s, frame_end_s, mx, my);
      end
      if (frame_end_s) fes++;
      if (VS_s) vs_on++;
      if (mx == 14) begin
        mx = 0;
        my = (my == 10) ? 0 : my + 1;
      end else begin
        mx++;
      end
      @(negedge CLK);
    end
    total++;
    if (fes != 2 || vs_on != 60 || x_s !== 10'd0 || y_s !== 10'd0) begin
      bad++;
      $display("FAIL frame_summary: frame_end=%0d vs_cycles=%0d x=%0d y=%0d required 2 60 0 0",
               fes, vs_on, x_s, y_s);
    end
    $display("frame: frame_end=%0d vs_cycles=%0d", fes, vs_on);
  endtask

  initial begin
    test_reset();
    test_line();
    test_ce_gating();
    test_async_reset();
    test_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
